// File: rtl/slurm16_irq_pkg.sv
// Shared definitions for the slurm16 interrupt scheduler.
//   NUM_IRQ_MAX : upper bound on the number of interrupt sources
//   IRQ_*       : register window addresses (ENABLE, PENDING, STATUS, SWTRIG)
//   irq_state_e : request/ack/done handshake states
package slurm16_irq_pkg;

    localparam int unsigned NUM_IRQ_MAX = 16;

    localparam logic [1:0] IRQ_ENABLE  = 2'd0;
    localparam logic [1:0] IRQ_PENDING = 2'd1;
    localparam logic [1:0] IRQ_STATUS  = 2'd2;
    localparam logic [1:0] IRQ_SWTRIG  = 2'd3;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_edge_sync.sv
// Synchroniser and rising-edge detector for one asynchronous interrupt source.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   src_i  : raw asynchronous source
//   edge_o : registered one-cycle pulse per synchronised rising edge
module irq_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    // Tracks which synchroniser stages hold real samples taken after reset.
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   prev_q;
    // A source must be seen low after reset before any edge is accepted, so a
    // line already high at reset release stays silent until it toggles.
    logic                   armed_q;
    logic                   edge_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            vld_q   <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], src_i};
            vld_q   <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= sync_out;
            armed_q <= armed_q | (vld_q[SYNC_STAGES-1] & ~sync_out);
            edge_q  <= sync_out & ~prev_q & armed_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/irq_scheduler.sv
// Prioritised interrupt controller: latches synchronised source edges as
// pending, masks them with enables, and runs a req/ack/done handshake with
// the CPU so only one interrupt is in service at a time. Source 0 wins.
//   CLK, RSTb           : clock, asynchronous active-low reset
//   irq_src             : raw asynchronous interrupt sources
//   ADDR/DATA_IN/WR/RD  : register window (ENABLE, PENDING, STATUS, SWTRIG)
//   DATA_OUT            : registered read data, valid the cycle after RD
//   irq_req/irq_vector  : request and source index presented to the CPU
//   irq_ack/irq_done    : CPU accept and return-from-interrupt pulses
module irq_scheduler
    import slurm16_irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RSTb,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [1:0]         ADDR,
    input  logic [15:0]        DATA_IN,
    output logic [15:0]        DATA_OUT,
    input  logic               WR,
    input  logic               RD,
    output logic               irq_req,
    output logic [3:0]         irq_vector,
    input  logic               irq_ack,
    input  logic               irq_done
);

    logic [NUM_IRQ-1:0] edge_hw;
    logic [NUM_IRQ-1:0] en_q, en_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] w1c, sw_set, ack_clr, act;
    logic [NUM_IRQ_MAX-1:0] pend_ext, en_ext;
    irq_state_e         state_q, state_d;
    logic [3:0]         vec_q, vec_d, sel_vec;
    logic               take_ack;
    logic [15:0]        data_out_q, data_out_d;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
        irq_edge_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i (CLK),
            .rst_ni(RSTb),
            .src_i (irq_src[g]),
            .edge_o(edge_hw[g])
        );
    end

    if (NUM_IRQ < NUM_IRQ_MAX) begin : g_unused
        logic unused_data_in;
        assign unused_data_in = ^DATA_IN[15:NUM_IRQ];
    end

    // Register writes and pending update; set sources beat every clear.
    always_comb begin
        en_d   = en_q;
        w1c    = '0;
        sw_set = '0;
        if (WR) begin
            unique case (ADDR)
                IRQ_ENABLE:  en_d   = DATA_IN[NUM_IRQ-1:0];
                IRQ_PENDING: w1c    = DATA_IN[NUM_IRQ-1:0];
                IRQ_SWTRIG:  sw_set = DATA_IN[NUM_IRQ-1:0];
                default: ;
            endcase
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_clr[i] = take_ack && (vec_q == 4'(i));
        end
        pend_d = (pend_q & ~w1c & ~ack_clr) | edge_hw | sw_set;
    end

    // Lowest-index active source wins.
    always_comb begin
        act     = pend_q & en_q;
        sel_vec = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (act[i]) sel_vec = 4'(i);
        end
        pend_ext = NUM_IRQ_MAX'(pend_q);
        en_ext   = NUM_IRQ_MAX'(en_q);
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        take_ack = 1'b0;
        unique case (state_q)
            IRQ_IDLE: begin
                if (|act) begin
                    vec_d   = sel_vec;
                    state_d = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                // Withdraw takes precedence: an ack for a vanished source is void.
                if (!pend_ext[vec_q] || !en_ext[vec_q]) begin
                    state_d = IRQ_IDLE;
                end else if (irq_ack) begin
                    take_ack = 1'b1;
                    state_d  = IRQ_SERVICE;
                end
            end
            IRQ_SERVICE: begin
                if (irq_done) state_d = IRQ_IDLE;
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    always_comb begin
        data_out_d = data_out_q;
        if (RD) begin
            unique case (ADDR)
                IRQ_ENABLE:  data_out_d = en_ext;
                IRQ_PENDING: data_out_d = pend_ext;
                IRQ_STATUS:  data_out_d = {6'd0, state_q == IRQ_SERVICE, state_q == IRQ_REQ,
                                           4'd0, vec_q};
                default:     data_out_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            en_q       <= '0;
            pend_q     <= '0;
            state_q    <= IRQ_IDLE;
            vec_q      <= '0;
            data_out_q <= '0;
        end else begin
            en_q       <= en_d;
            pend_q     <= pend_d;
            state_q    <= state_d;
            vec_q      <= vec_d;
            data_out_q <= data_out_d;
        end
    end

    assign irq_req    = (state_q == IRQ_REQ);
    assign irq_vector = vec_q;
    assign DATA_OUT   = data_out_q;

endmodule

// File: tb/tb_irq_scheduler.sv
// Directed self-checking bench for irq_scheduler (NUM_IRQ=8, SYNC_STAGES=2).
module tb_irq_scheduler;

    logic        CLK;
    logic        RSTb;
    logic [7:0]  irq_src;
    logic [1:0]  ADDR;
    logic [15:0] DATA_IN;
    logic [15:0] DATA_OUT;
    logic        WR;
    logic        RD;
    logic        irq_req;
    logic [3:0]  irq_vector;
    logic        irq_ack;
    logic        irq_done;

    int n_tests = 0;
    int n_fail  = 0;

    irq_scheduler #(
        .NUM_IRQ    (8),
        .SYNC_STAGES(2)
    ) dut (
        .CLK       (CLK),
        .RSTb      (RSTb),
        .irq_src   (irq_src),
        .ADDR      (ADDR),
        .DATA_IN   (DATA_IN),
        .DATA_OUT  (DATA_OUT),
        .WR        (WR),
        .RD        (RD),
        .irq_req   (irq_req),
        .irq_vector(irq_vector),
        .irq_ack   (irq_ack),
        .irq_done  (irq_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        ADDR    = a;
        DATA_IN = d;
        WR      = 1'b1;
        step();
        WR      = 1'b0;
        DATA_IN = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [15:0] exp);
        ADDR = a;
        RD   = 1'b1;
        step();
        RD   = 1'b0;
        chk(tag, DATA_OUT, exp);
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1;
        step();
        irq_done = 1'b0;
    endtask

    initial begin
        RSTb     = 1'b0;
        irq_src  = '0;
        ADDR     = '0;
        DATA_IN  = '0;
        WR       = 1'b0;
        RD       = 1'b0;
        irq_ack  = 1'b0;
        irq_done = 1'b0;
        #1;
        chk("rst_req", 16'(irq_req), 16'h0);
        chk("rst_vec", 16'(irq_vector), 16'h0);
        chk("rst_dout", DATA_OUT, 16'h0);
        step();
        step();
        RSTb = 1'b1;
        repeat (3) step();
        rd_chk("rst_enable", 2'd0, 16'h0000);
        rd_chk("rst_pending", 2'd1, 16'h0000);

        // Source 0: edge before E0 -> PENDING at E3, irq_req at E4.
        wr(2'd0, 16'h0001);
        irq_src[0] = 1'b1;
        step();
        step();
        step();
        irq_src[0] = 1'b0;
        step();
        chk("s0_req_e3", 16'(irq_req), 16'h0);
        rd_chk("s0_pend_e4", 2'd1, 16'h0001);
        chk("s0_req_e4", 16'(irq_req), 16'h1);
        chk("s0_vec_e4", 16'(irq_vector), 16'h0);
        pulse_ack();
        chk("s0_req_ack", 16'(irq_req), 16'h0);
        rd_chk("s0_pend_ack", 2'd1, 16'h0000);
        rd_chk("s0_status_svc", 2'd2, 16'h0200);
        pulse_done();
        rd_chk("s0_status_idle", 2'd2, 16'h0000);

        // Priority: sources 5 and 2 rise together.
        wr(2'd0, 16'h00FF);
        irq_src = 8'h24;
        repeat (5) step();
        chk("pri_req", 16'(irq_req), 16'h1);
        chk("pri_vec2", 16'(irq_vector), 16'h2);
        pulse_ack();
        chk("pri_req_ack", 16'(irq_req), 16'h0);
        pulse_done();
        chk("pri_req_done", 16'(irq_req), 16'h0);
        step();
        chk("pri_req2", 16'(irq_req), 16'h1);
        chk("pri_vec5", 16'(irq_vector), 16'h5);
        pulse_ack();
        pulse_done();
        rd_chk("pri_level_no_reset", 2'd1, 16'h0000);
        irq_src = '0;
        repeat (3) step();

        // Masking: pending latched while disabled, request once enabled.
        wr(2'd0, 16'h0000);
        irq_src[3] = 1'b1;
        repeat (4) step();
        rd_chk("mask_pend", 2'd1, 16'h0008);
        chk("mask_req0", 16'(irq_req), 16'h0);
        irq_src[3] = 1'b0;
        wr(2'd0, 16'h0008);
        chk("mask_req_wr", 16'(irq_req), 16'h0);
        step();
        chk("mask_req1", 16'(irq_req), 16'h1);
        chk("mask_vec3", 16'(irq_vector), 16'h3);
        pulse_ack();
        pulse_done();

        // Withdraw: W1C of the requested source drops irq_req.
        wr(2'd0, 16'h0002);
        wr(2'd3, 16'h0002);
        step();
        chk("wd_req", 16'(irq_req), 16'h1);
        chk("wd_vec1", 16'(irq_vector), 16'h1);
        wr(2'd1, 16'h0002);
        step();
        chk("wd_req_drop", 16'(irq_req), 16'h0);
        rd_chk("wd_status", 2'd2, 16'h0001);

        // Collision: hardware edge on src 4 in the same cycle as its ack.
        wr(2'd0, 16'h0010);
        wr(2'd3, 16'h0010);
        irq_src[4] = 1'b1;
        step();
        chk("col_req", 16'(irq_req), 16'h1);
        chk("col_vec4", 16'(irq_vector), 16'h4);
        step();
        step();
        pulse_ack();
        chk("col_req_ack", 16'(irq_req), 16'h0);
        rd_chk("col_pend_kept", 2'd1, 16'h0010);
        rd_chk("col_status_svc", 2'd2, 16'h0204);
        pulse_done();
        chk("col_req_done", 16'(irq_req), 16'h0);
        step();
        chk("col_rereq", 16'(irq_req), 16'h1);
        chk("col_revec4", 16'(irq_vector), 16'h4);
        irq_src[4] = 1'b0;
        pulse_ack();
        pulse_done();

        // Reset mid-REQ, then a source held high across release stays silent.
        wr(2'd0, 16'h0044);
        rd_chk("rr_enable", 2'd0, 16'h0044);
        irq_src[6] = 1'b1;
        wr(2'd3, 16'h0004);
        step();
        chk("rr_req_pre", 16'(irq_req), 16'h1);
        chk("rr_vec_pre", 16'(irq_vector), 16'h2);
        #3;
        RSTb = 1'b0;
        #1;
        chk("rr_req_async", 16'(irq_req), 16'h0);
        chk("rr_vec_async", 16'(irq_vector), 16'h0);
        chk("rr_dout_async", DATA_OUT, 16'h0);
        step();
        step();
        RSTb = 1'b1;
        rd_chk("rr_enable_clr", 2'd0, 16'h0000);
        rd_chk("rr_pend_clr", 2'd1, 16'h0000);
        wr(2'd0, 16'h0040);
        repeat (6) step();
        chk("rr_held_noreq", 16'(irq_req), 16'h0);
        rd_chk("rr_held_nopend", 2'd1, 16'h0000);
        rd_chk("swtrig_reads0", 2'd3, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
